tdma_rx_parser: RTL and testbench

TDMA_RX_PARSER -- requirements
Module: tdma_rx_parser

---
 rtl/tdma_rx_parser.sv | 184 ++++++++++++++++++
 tb/tb_tdma_rx_parser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tdma_rx_parser.sv
// TDMA receive-frame parser: fetches the 16-byte payload header of a received
// frame via one IPIC burst read, decodes PING / ACK_PING frames and keeps
// saturating statistics counters.
module tdma_rx_parser #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          C_LENGTH_WIDTH = 14,
  parameter logic [31:0] PAYLOAD_OFFSET = 32'h20,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx_req_valid,
  input  logic [ADDR_WIDTH-1:0]     rx_req_addr,
  output logic                      rx_req_ready,
  output logic                      ipic_start,
  output logic [2:0]                ipic_type,
  input  logic                      ipic_ack,
  input  logic                      ipic_done_wire,
  output logic [ADDR_WIDTH-1:0]     read_addr,
  output logic [C_LENGTH_WIDTH-1:0] read_length,
  input  logic [4*DATA_WIDTH-1:0]   bunch_read_data,
  output logic                      recv_ping,
  output logic                      recv_ack_ping,
  output logic [DATA_WIDTH-1:0]     recv_seq,
  output logic [DATA_WIDTH-1:0]     recv_sec,
  output logic [DATA_WIDTH-1:0]     recv_counter2,
  output logic [15:0]               rx_ping_count,
  output logic [15:0]               rx_ackping_count,
  output logic [15:0]               rx_drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] FLAG_PING     = 6'd1;
  localparam logic [5:0] FLAG_ACK_PING = 6'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_ACK, S_WAIT_DONE, S_PARSE, S_EMIT
  } state_t;

  state_t                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]     read_addr_q, read_addr_d;
  logic [C_LENGTH_WIDTH-1:0] read_length_q, read_length_d;
  logic [4*DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]     seq_q, seq_d, sec_q, sec_d, cnt2_q, cnt2_d;
  logic                      is_ping_q, is_ping_d;
  logic [TW-1:0]             timeout_q, timeout_d;
  logic [15:0]               ping_cnt_q, ping_cnt_d;
  logic [15:0]               ack_cnt_q, ack_cnt_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;

  logic [5:0] flag;
  logic       frame_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign flag     = data_q[5:0];
  assign frame_ok = (data_q[DATA_WIDTH-1:6] == '0) &&
                    ((flag == FLAG_PING) || (flag == FLAG_ACK_PING));

  // Next-state and datapath update for the fetch/decode sequence.
  always_comb begin
    state_d       = state_q;
    read_addr_d   = read_addr_q;
    read_length_d = read_length_q;
    data_d        = data_q;
    seq_d         = seq_q;
    sec_d         = sec_q;
    cnt2_d        = cnt2_q;
    is_ping_d     = is_ping_q;
    timeout_d     = timeout_q;
    ping_cnt_d    = ping_cnt_q;
    ack_cnt_d     = ack_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rx_req_valid && ready_q) begin
          read_addr_d   = rx_req_addr + ADDR_WIDTH'(PAYLOAD_OFFSET);
          read_length_d = C_LENGTH_WIDTH'(16);
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        timeout_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A completion seen before the request is acknowledged is ignored.
        if (ipic_ack) begin
          timeout_d = '0;
          state_d   = S_WAIT_DONE;
        end else if (timeout_q == TO_LAST) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = S_IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (ipic_done_wire) begin
          data_d  = bunch_read_data;
          state_d = S_PARSE;
        end else if (timeout_q == TO_LAST) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = S_IDLE;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      S_PARSE: begin
        if (frame_ok) begin
          seq_d     = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
          sec_d     = data_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
          cnt2_d    = data_q[4*DATA_WIDTH-1:3*DATA_WIDTH];
          is_ping_d = (flag == FLAG_PING);
          state_d   = S_EMIT;
        end else begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = S_IDLE;
        end
      end
      S_EMIT: begin
        if (is_ping_q) ping_cnt_d = sat_inc(ping_cnt_q);
        else           ack_cnt_d  = sat_inc(ack_cnt_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Ready is registered so that it reads 0 while reset is held.
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      read_addr_q   <= '0;
      read_length_q <= '0;
      data_q        <= '0;
      seq_q         <= '0;
      sec_q         <= '0;
      cnt2_q        <= '0;
      is_ping_q     <= 1'b0;
      timeout_q     <= '0;
      ping_cnt_q    <= '0;
      ack_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      read_addr_q   <= read_addr_d;
      read_length_q <= read_length_d;
      data_q        <= data_d;
      seq_q         <= seq_d;
      sec_q         <= sec_d;
      cnt2_q        <= cnt2_d;
      is_ping_q     <= is_ping_d;
      timeout_q     <= timeout_d;
      ping_cnt_q    <= ping_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign rx_req_ready     = ready_q;
  assign ipic_start       = (state_q == S_REQ) || (state_q == S_WAIT_ACK);
  assign ipic_type        = 3'd0;
  assign read_addr        = read_addr_q;
  assign read_length      = read_length_q;
  assign recv_ping        = (state_q == S_EMIT) && is_ping_q;
  assign recv_ack_ping    = (state_q == S_EMIT) && !is_ping_q;
  assign recv_seq         = seq_q;
  assign recv_sec         = sec_q;
  assign recv_counter2    = cnt2_q;
  assign rx_ping_count    = ping_cnt_q;
  assign rx_ackping_count = ack_cnt_q;
  assign rx_drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_tdma_rx_parser.sv
// Directed bench for tdma_rx_parser; inputs are driven and outputs sampled on
// the falling clock edge, the DUT works on the rising edge.
module tb_tdma_rx_parser;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_req_valid = 1'b0;
  logic [31:0]  rx_req_addr = '0;
  logic         rx_req_ready;
  logic         ipic_start;
  logic [2:0]   ipic_type;
  logic         ipic_ack = 1'b0;
  logic         ipic_done_wire = 1'b0;
  logic [31:0]  read_addr;
  logic [13:0]  read_length;
  logic [127:0] bunch_read_data = '0;
  logic         recv_ping, recv_ack_ping;
  logic [31:0]  recv_seq, recv_sec, recv_counter2;
  logic [15:0]  rx_ping_count, rx_ackping_count, rx_drop_count;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D_PING  = {32'h0000_0ABC, 32'h5F00_0001, 32'h7, 32'h1};
  localparam logic [127:0] D_ACK   = {32'h0000_0ABC, 32'h5F00_0001, 32'h7, 32'h2};
  localparam logic [127:0] D_BADHI = {32'h1, 32'h2, 32'h99, 32'h0000_0041};
  localparam logic [127:0] D_FLAG3 = {32'h1, 32'h2, 32'h98, 32'h3};
  localparam logic [127:0] D_JUNK  = {4{32'hFFFF_FFFF}};

  tdma_rx_parser dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_req_valid    (rx_req_valid),
    .rx_req_addr     (rx_req_addr),
    .rx_req_ready    (rx_req_ready),
    .ipic_start      (ipic_start),
    .ipic_type       (ipic_type),
    .ipic_ack        (ipic_ack),
    .ipic_done_wire  (ipic_done_wire),
    .read_addr       (read_addr),
    .read_length     (read_length),
    .bunch_read_data (bunch_read_data),
    .recv_ping       (recv_ping),
    .recv_ack_ping   (recv_ack_ping),
    .recv_seq        (recv_seq),
    .recv_sec        (recv_sec),
    .recv_counter2   (recv_counter2),
    .rx_ping_count   (rx_ping_count),
    .rx_ackping_count(rx_ackping_count),
    .rx_drop_count   (rx_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".ready"}, 32'(rx_req_ready), 32'd0);
    check_eq({tag, ".start"}, 32'(ipic_start), 32'd0);
    check_eq({tag, ".type"}, 32'(ipic_type), 32'd0);
    check_eq({tag, ".raddr"}, read_addr, 32'd0);
    check_eq({tag, ".rlen"}, 32'(read_length), 32'd0);
    check_eq({tag, ".pulses"}, {30'd0, recv_ping, recv_ack_ping}, 32'd0);
    check_eq({tag, ".seq"}, recv_seq, 32'd0);
    check_eq({tag, ".sec"}, recv_sec, 32'd0);
    check_eq({tag, ".cnt2"}, recv_counter2, 32'd0);
    check_eq({tag, ".counts"}, {16'(rx_ping_count + rx_ackping_count), rx_drop_count}, 32'd0);
  endtask

  // Holds reset for two rising edges, then releases and checks ready.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_all_zero("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst.ready_after", 32'(rx_req_ready), 32'd1);
  endtask

  // Presents one request and checks the latched burst parameters in REQ.
  task automatic start_req(input logic [31:0] addr, input logic [31:0] exp_raddr);
    for (int i = 0; i < 20 && rx_req_ready !== 1'b1; i++) @(negedge clk);
    check_eq("req.ready", 32'(rx_req_ready), 32'd1);
    rx_req_valid = 1'b1;
    rx_req_addr  = addr;
    @(negedge clk);
    rx_req_valid = 1'b0;
    check_eq("req.start", 32'(ipic_start), 32'd1);
    check_eq("req.busy", 32'(rx_req_ready), 32'd0);
    check_eq("req.raddr", read_addr, exp_raddr);
    check_eq("req.rlen", 32'(read_length), 32'd16);
    check_eq("req.type", 32'(ipic_type), 32'd0);
  endtask

  // From REQ: a stray completion during WAIT_ACK, then the ack; ends in WAIT_DONE.
  task automatic ack_phase();
    @(negedge clk);
    ipic_done_wire  = 1'b1;
    bunch_read_data = D_JUNK;
    @(negedge clk);
    ipic_done_wire = 1'b0;
    check_eq("ack.start_held", 32'(ipic_start), 32'd1);
    ipic_ack = 1'b1;
    @(negedge clk);
    ipic_ack = 1'b0;
    check_eq("ack.start_fell", 32'(ipic_start), 32'd0);
  endtask

  // From WAIT_DONE: deliver data, check the pulse two cycles later.
  task automatic done_phase(input logic [127:0] data, input logic exp_ping, input logic exp_ack);
    logic [31:0] seq_before;
    seq_before      = recv_seq;
    ipic_done_wire  = 1'b1;
    bunch_read_data = data;
    @(negedge clk);
    ipic_done_wire = 1'b0;
    check_eq("parse.no_pulse", {30'd0, recv_ping, recv_ack_ping}, 32'd0);
    @(negedge clk);
    check_eq("emit.pulses", {30'd0, recv_ping, recv_ack_ping}, {30'd0, exp_ping, exp_ack});
    if (exp_ping || exp_ack) begin
      check_eq("emit.seq", recv_seq, data[63:32]);
      check_eq("emit.sec", recv_sec, data[95:64]);
      check_eq("emit.cnt2", recv_counter2, data[127:96]);
      @(negedge clk);
    end else begin
      check_eq("drop.seq_kept", recv_seq, seq_before);
    end
    check_eq("end.idle", 32'(rx_req_ready), 32'd1);
    check_eq("end.no_pulse", {30'd0, recv_ping, recv_ack_ping}, 32'd0);
    $display("frame word0=%h seq=%h ping=%0d ack=%0d drop=%0d",
             data[31:0], recv_seq, rx_ping_count, rx_ackping_count, rx_drop_count);
  endtask

  initial begin
    int hi;
    #1 check_all_zero("init");
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("init.ready", 32'(rx_req_ready), 32'd1);

    // V1: PING frame
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_PING, 1'b1, 1'b0);
    check_eq("v1.ping_cnt", 32'(rx_ping_count), 32'd1);

    // V2: ACK_PING frame
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_ACK, 1'b0, 1'b1);
    check_eq("v2.ack_cnt", 32'(rx_ackping_count), 32'd1);
    check_eq("v2.ping_cnt", 32'(rx_ping_count), 32'd1);

    // V3: nonzero reserved bits, then flag 3: both dropped
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_BADHI, 1'b0, 1'b0);
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_FLAG3, 1'b0, 1'b0);
    check_eq("v3.drop_cnt", 32'(rx_drop_count), 32'd2);
    check_eq("v3.seq", recv_seq, 32'h7);

    // V4: ack withheld; start stays high for REQ plus 1024 wait cycles
    do_reset();
    start_req(32'h2000_0000, 32'h2000_0020);
    hi = 0;
    while (ipic_start === 1'b1 && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    check_eq("v4.start_cycles", 32'(hi), 32'd1025);
    check_eq("v4.drop_cnt", 32'(rx_drop_count), 32'd1);
    check_eq("v4.ready", 32'(rx_req_ready), 32'd1);
    $display("timeout start_high_cycles=%0d drop=%0d", hi, rx_drop_count);

    // V5: reset during WAIT_DONE clears everything, then V1 again
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_PING, 1'b1, 1'b0);
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    reset_n = 1'b0;
    #1 check_all_zero("v5");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("v5.ready_after", 32'(rx_req_ready), 32'd1);
    start_req(32'h1000_0000, 32'h1000_0020);
    ack_phase();
    done_phase(D_PING, 1'b1, 1'b0);
    check_eq("v5.ping_cnt", 32'(rx_ping_count), 32'd1);
    check_eq("v5.drop_cnt", 32'(rx_drop_count), 32'd0);

    // V6: address wraps modulo 2^32
    start_req(32'hFFFF_FFF0, 32'h0000_0010);
    ack_phase();
    done_phase(D_PING, 1'b1, 1'b0);
    check_eq("v6.ping_cnt", 32'(rx_ping_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
